// File: rtl/fetch_unit_if.sv
// Fetch unit interface: redirect control, instruction delivery and program-memory bus.
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Fetch unit side.
  modport master (
    input  redirect, redirect_pc, instr_ready, mem_ack, mem_rdata,
    output instr_valid, instruction, instr_pc, mem_req, mem_addr
  );

  // Core pipeline / memory side.
  modport slave (
    output redirect, redirect_pc, instr_ready, mem_ack, mem_rdata,
    input  instr_valid, instruction, instr_pc, mem_req, mem_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch unit with a small prefetch FIFO and redirect support.
// At most one memory read is outstanding; reads are only issued when the FIFO
// is guaranteed to have room for the returning word.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t        state, state_d;
  logic [31:0]   fetch_addr;
  logic [31:0]   req_addr;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          valid, pop, push, issue;

  // A redirect flushes the FIFO, so any simultaneous pop is dropped.
  assign valid = (count != '0);
  assign pop   = valid && bus.instr_ready && !bus.redirect;

  // Next-state logic: issue a read when room is guaranteed, push or drop returning data.
  always_comb begin
    state_d = state;
    push    = 1'b0;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.redirect && ((count < FULL) || pop)) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          push    = !bus.redirect;
          state_d = IDLE;
        end else if (bus.redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Fetch address advances only on an accepted return; the request address is latched at issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_addr <= RESET_PC;
      req_addr   <= '0;
    end else begin
      if (bus.redirect)  fetch_addr <= bus.redirect_pc & 32'hFFFF_FFFC;
      else if (push)     fetch_addr <= fetch_addr + 32'd4;
      if (issue)         req_addr   <= fetch_addr;
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst || bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= req_addr;
      data_q[wr_ptr] <= bus.mem_rdata;
    end
  end

  assign bus.instr_valid = valid;
  assign bus.instruction = valid ? data_q[rd_ptr] : '0;
  assign bus.instr_pc    = valid ? pc_q[rd_ptr]   : '0;
  assign bus.mem_req     = (state != IDLE);
  assign bus.mem_addr    = req_addr;

endmodule
